// File: rtl/led_code_sched.sv
// Multiplexed LED code scheduler: shows each valid 16-bit table code one nibble at a time, then a gap.
// Optional macro LED_CODE_SCHED_MARKER_EN drives {1'b1, SYM_IDX} on LED_DATA during the gap instead of zero.
module led_code_sched #(
   parameter logic [13:0] DIV_FACTOR = 14'h3F98,
   parameter logic [7:0]  DWELL      = 8'd200
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        WR_EN,
   input  logic [2:0]  WR_ADDR,
   input  logic [16:0] WR_DATA,
   output logic        WR_READY,
   input  logic        START,
   input  logic        STOP,
   input  logic        REPEAT,
   output logic [3:0]  LED_DATA,
   output logic [2:0]  SYM_IDX,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t      state;
   logic [16:0] table_q [8];
   logic [13:0] presc;
   logic [7:0]  dwell;
   logic [1:0]  nibble;

   logic        wr_accept;
   logic        tick;
   logic        last_dwell;
   logic [1:0]  nib_next;
   logic [16:0] eff_entry [8];
   logic [7:0]  valid_now;
   logic [3:0]  first_hit;
   logic [3:0]  above_hit;
   logic [2:0]  gap_target;
   logic        gap_continue;
   logic [3:0]  gap_led;

   // Lowest valid index at or above lo, as {found, index}.
   function automatic logic [3:0] pick(input logic [7:0] v, input logic [3:0] lo);
      pick = 4'b0000;
      for (int i = 7; i >= 0; i--)
         if (v[i] && 4'(i) >= lo) pick = {1'b1, 3'(i)};
   endfunction

   assign WR_READY   = ~BUSY;
   assign wr_accept  = WR_EN & ~BUSY;
   assign tick       = (state != IDLE) && (presc == DIV_FACTOR);
   assign last_dwell = (dwell == DWELL - 8'd1);
   assign nib_next   = nibble + 2'd1;

   // NOTE: a START on the same edge as a write must see the new entry, so decisions use the
   // table merged with the pending write rather than the stored copy.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         eff_entry[i] = table_q[i];
         if (wr_accept && WR_ADDR == 3'(i)) eff_entry[i] = WR_DATA;
         valid_now[i] = eff_entry[i][16];
      end
   end

   assign first_hit    = pick(valid_now, 4'd0);
   assign above_hit    = pick(valid_now, {1'b0, SYM_IDX} + 4'd1);
   assign gap_target   = above_hit[3] ? above_hit[2:0] : first_hit[2:0];
   assign gap_continue = above_hit[3] | (REPEAT & first_hit[3]);

`ifdef LED_CODE_SCHED_MARKER_EN
   assign gap_led = {1'b1, SYM_IDX};
`else
   assign gap_led = 4'b0000;
`endif

   // NOTE: the code table is a bank of flops, not a RAM, so it is cleared by nRST with everything else.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         presc    <= '0;
         dwell    <= '0;
         nibble   <= '0;
         LED_DATA <= '0;
         SYM_IDX  <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         for (int i = 0; i < 8; i++) table_q[i] <= '0;
      end else begin
         DONE <= 1'b0;
         if (wr_accept) table_q[WR_ADDR] <= WR_DATA;

         if (STOP) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            LED_DATA <= 4'b0000;
            presc    <= '0;
            dwell    <= '0;
            nibble   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  LED_DATA <= 4'b0000;
                  if (START) begin
                     presc  <= '0;
                     dwell  <= '0;
                     nibble <= '0;
                     if (first_hit[3]) begin
                        state    <= SHOW;
                        BUSY     <= 1'b1;
                        SYM_IDX  <= first_hit[2:0];
                        LED_DATA <= eff_entry[first_hit[2:0]][3:0];
                     end else begin
                        DONE <= 1'b1;
                     end
                  end
               end

               SHOW, GAP: begin
                  presc <= tick ? 14'd0 : presc + 14'd1;
                  if (tick) begin
                     dwell <= last_dwell ? 8'd0 : dwell + 8'd1;
                     if (last_dwell && state == SHOW) begin
                        if (nibble == 2'd3) begin
                           state    <= GAP;
                           LED_DATA <= gap_led;
                        end else begin
                           nibble   <= nib_next;
                           LED_DATA <= eff_entry[SYM_IDX][{nib_next, 2'b00} +: 4];
                        end
                     end else if (last_dwell) begin
                        // End of gap: advance to the next valid entry, or finish the pass.
                        if (!above_hit[3]) DONE <= 1'b1;
                        nibble <= '0;
                        if (gap_continue) begin
                           state    <= SHOW;
                           SYM_IDX  <= gap_target;
                           LED_DATA <= eff_entry[gap_target][3:0];
                        end else begin
                           state    <= IDLE;
                           BUSY     <= 1'b0;
                           LED_DATA <= 4'b0000;
                           presc    <= '0;
                        end
                     end
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_code_sched.sv
// Self-checking bench for led_code_sched: directed scenarios plus randomized traffic
// compared every cycle against a timeline model of the display schedule.
module tb_led_code_sched;

   localparam int DIV      = 3;
   localparam int DW       = 2;
   localparam int SEG      = (DIV + 1) * DW;  // clocks per nibble or gap
   localparam int SYM_CLKS = 5 * SEG;         // clocks per displayed entry

   logic        CLK = 1'b0;
   logic        nRST;
   logic        WR_EN;
   logic [2:0]  WR_ADDR;
   logic [16:0] WR_DATA;
   logic        WR_READY;
   logic        START;
   logic        STOP;
   logic        REPEAT;
   logic [3:0]  LED_DATA;
   logic [2:0]  SYM_IDX;
   logic        BUSY;
   logic        DONE;

   led_code_sched #(.DIV_FACTOR(14'(DIV)), .DWELL(8'(DW))) dut (
      .CLK(CLK), .nRST(nRST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .WR_READY(WR_READY), .START(START), .STOP(STOP), .REPEAT(REPEAT),
      .LED_DATA(LED_DATA), .SYM_IDX(SYM_IDX), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   logic [16:0] m_tbl [8];
   bit          m_active;
   int          m_t;
   int          m_pos;
   int          m_list [$];
   logic [2:0]  m_sym;
   bit          m_done;

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) m_tbl[i] = '0;
      m_active = 0;
      m_t      = 0;
      m_pos    = 0;
      m_sym    = '0;
      m_done   = 0;
      m_list.delete();
   endfunction

   function automatic void build_list();
      m_list.delete();
      for (int i = 0; i < 8; i++) if (m_tbl[i][16]) m_list.push_back(i);
   endfunction

   function automatic void model_step();
      bit was_busy = m_active;
      m_done = 0;
      if (WR_EN && !was_busy) m_tbl[WR_ADDR] = WR_DATA;
      if (STOP) begin
         m_active = 0;
      end else if (!m_active) begin
         if (START) begin
            build_list();
            if (m_list.size() == 0) m_done = 1;
            else begin
               m_active = 1;
               m_t      = 0;
               m_pos    = 0;
            end
         end
      end else begin
         m_t++;
         if (m_t == SYM_CLKS) begin
            m_t = 0;
            m_pos++;
            if (m_pos == m_list.size()) begin
               m_done = 1;
               m_pos  = 0;
               if (!REPEAT) m_active = 0;
            end
         end
      end
      if (m_active) m_sym = 3'(m_list[m_pos]);
   endfunction

   function automatic logic [3:0] model_led();
      int ph;
      if (!m_active) return 4'h0;
      ph = m_t / SEG;
      if (ph < 4) return 4'((m_tbl[m_sym][15:0] >> (4 * ph)) & 16'hF);
`ifdef LED_CODE_SCHED_MARKER_EN
      return {1'b1, m_sym};
`else
      return 4'h0;
`endif
   endfunction

   // Compare process: every cycle, just after the rising edge.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (!nRST) model_reset();
         else model_step();
         check("cycle_outputs", {LED_DATA, SYM_IDX, BUSY, DONE, WR_READY},
               {model_led(), m_sym, m_active, m_done, ~m_active});
      end
   end

   // ---------------- stimulus ----------------
   task automatic write_entry(input logic [2:0] a, input logic [16:0] d);
      WR_EN   = 1'b1;
      WR_ADDR = a;
      WR_DATA = d;
      @(negedge CLK);
      WR_EN   = 1'b0;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   logic [3:0] exp_nib [5];

   initial begin
      nRST = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
      START = 1'b0; STOP = 1'b0; REPEAT = 1'b0;
      exp_nib[0] = 4'h3; exp_nib[1] = 4'hC; exp_nib[2] = 4'h5; exp_nib[3] = 4'hA;
`ifdef LED_CODE_SCHED_MARKER_EN
      exp_nib[4] = 4'hA;
`else
      exp_nib[4] = 4'h0;
`endif
      repeat (3) @(negedge CLK);
      check("reset_outputs", {LED_DATA, SYM_IDX, BUSY, DONE, WR_READY}, 10'b0000_000_0_0_1);
      nRST = 1'b1;
      @(negedge CLK);

      // Single entry 2 = A5C3: nibbles 3,C,5,A then gap, each 8 clocks.
      write_entry(3'd2, {1'b1, 16'hA5C3});
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         check("pass1_led", LED_DATA, exp_nib[k]);
         check("pass1_sym", SYM_IDX, 3'd2);
         repeat (8) @(negedge CLK);
      end
      check("pass1_done", {DONE, BUSY, LED_DATA}, 6'b10_0000);
      @(negedge CLK);
      check("pass1_done_pulse", DONE, 1'b0);

      // All entries invalid: START only pulses DONE.
      write_entry(3'd2, {1'b0, 16'hA5C3});
      pulse_start();
      check("empty_start", {DONE, BUSY, LED_DATA}, 6'b10_0000);
      @(negedge CLK);
      check("empty_done_pulse", {DONE, BUSY}, 2'b00);

      // Entries 0 and 5, REPEAT: 0,5,0,... with a rejected write to 5 mid-SHOW.
      write_entry(3'd0, {1'b1, 16'h1234});
      write_entry(3'd5, {1'b1, 16'hBEEF});
      REPEAT = 1'b1;
      pulse_start();
      check("rep_sym0", SYM_IDX, 3'd0);
      repeat (8) @(negedge CLK);
      WR_EN = 1'b1; WR_ADDR = 3'd5; WR_DATA = {1'b1, 16'h0000};
      check("wr_ready_busy", WR_READY, 1'b0);
      @(negedge CLK);
      WR_EN = 1'b0;
      repeat (31) @(negedge CLK);
      check("rep_sym5", {SYM_IDX, LED_DATA}, {3'd5, 4'hF});
      repeat (40) @(negedge CLK);
      check("rep_wrap", {SYM_IDX, DONE, BUSY}, {3'd0, 1'b1, 1'b1});
      repeat (5) @(negedge CLK);
      STOP = 1'b1; START = 1'b1;
      @(negedge CLK);
      STOP = 1'b0; START = 1'b0;
      check("stop_wins", {BUSY, LED_DATA, DONE}, 6'b0_0000_0);
      REPEAT = 1'b0;

      // Reset in the middle of the first gap clears outputs and the table.
      pulse_start();
      repeat (34) @(negedge CLK);
      #2 nRST = 1'b0;
      #1 check("async_reset", {LED_DATA, SYM_IDX, BUSY, DONE, WR_READY}, 10'b0000_000_0_0_1);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      pulse_start();
      check("table_cleared", {DONE, BUSY, LED_DATA}, 6'b10_0000);

      // Randomized traffic, checked every cycle by the compare process.
      for (int c = 0; c < 4000; c++) begin
         WR_EN   = ($urandom % 6) == 0;
         WR_ADDR = 3'($urandom % 8);
         WR_DATA = {1'($urandom % 2), 16'($urandom)};
         START   = ($urandom % 30) == 0;
         STOP    = ($urandom % 400) == 0;
         REPEAT  = ($urandom % 3) != 0;
         @(negedge CLK);
      end
      WR_EN = 1'b0; START = 1'b0; STOP = 1'b1; REPEAT = 1'b0;
      @(negedge CLK);
      STOP = 1'b0;
      repeat (4) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
